// File: rtl/corr_pkg.sv
// Shared constants for the correlation back-end: mode bit positions,
// default geometry and the accumulator width rule.
package corr_pkg;

  localparam int MODE_RND = 0;
  localparam int MODE_SAT = 1;

  localparam int DEF_DW    = 8;
  localparam int DEF_K     = 4;
  localparam int DEF_LANES = 4;
  localparam int DEF_SHIFT = 4;

  // A full window of maximum-value products never overflows this width.
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction

endpackage

// File: rtl/corr_scale_sat.sv
// Narrows one window sum to a lane value: optional round-half-up,
// right shift, then either saturate or wrap to DW bits.
module corr_scale_sat
  import corr_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int DW    = 8,
  parameter int SHIFT = 4
) (
  input  logic [ACC_W-1:0] i_sum,
  input  logic [1:0]       i_mode,
  output logic [DW-1:0]    o_result
);

  // One extra bit so the rounding add can never wrap.
  localparam logic [ACC_W:0] RND_TERM =
    (SHIFT > 0) ? ((ACC_W + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  logic [ACC_W:0] w_sum;
  logic [ACC_W:0] w_shr;

  assign w_sum = {1'b0, i_sum} + (i_mode[MODE_RND] ? RND_TERM : '0);
  assign w_shr = w_sum >> SHIFT;

  always_comb begin
    o_result = w_shr[DW-1:0];
    if (i_mode[MODE_SAT] && (|w_shr[ACC_W:DW]))
      o_result = '1;
  end

endmodule

// File: rtl/corr_window_mac.sv
// K*K-tap correlation MAC with a loadable coefficient file; packs LANES
// scaled window results per output word behind a ready/valid handshake.
module corr_window_mac
  import corr_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int K     = DEF_K,
  parameter int LANES = DEF_LANES,
  parameter int SHIFT = DEF_SHIFT,
  parameter int ACC_W = acc_width(DW, K)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coef_wr,
  input  logic [$clog2(K*K)-1:0]       coef_idx,
  input  logic [DW-1:0]                coef_data,
  input  logic [1:0]                   mode,
  input  logic                         px_valid,
  output logic                         px_ready,
  input  logic [DW-1:0]                px_data,
  input  logic                         px_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*DW-1:0]          out_data,
  output logic [$clog2(LANES+1)-1:0]   out_lanes,
  output logic                         out_last,
  output logic                         busy
);

  localparam int TAPS = K * K;
  localparam int IW   = $clog2(TAPS);
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int OW   = $clog2(LANES + 1);

  localparam logic [IW-1:0] LAST_TAP  = IW'(TAPS - 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  logic [DW-1:0]       r_coef [TAPS];
  logic [IW-1:0]       r_idx;
  logic [ACC_W-1:0]    r_acc;
  logic [LW-1:0]       r_lane_idx;
  logic [DW-1:0]       r_lanes [LANES];
  logic                r_out_valid;
  logic [LANES*DW-1:0] r_out_data;
  logic [OW-1:0]       r_out_lanes;
  logic                r_out_last;

  logic                w_accept;
  logic                w_done;
  logic                w_emit;
  logic [ACC_W-1:0]    w_prod;
  logic [ACC_W-1:0]    w_sum;
  logic [DW-1:0]       w_result;
  logic [LANES*DW-1:0] w_word;

  assign px_ready = ~r_out_valid | out_ready;
  assign w_accept = px_valid & px_ready;
  assign w_done   = w_accept & (r_idx == LAST_TAP);
  assign w_emit   = w_done & ((r_lane_idx == LAST_LANE) | px_last);

  // Coefficient is read combinationally, so a same-cycle write is seen one tap later.
  assign w_prod = ACC_W'(px_data) * ACC_W'(r_coef[r_idx]);
  assign w_sum  = ((r_idx == '0) ? '0 : r_acc) + w_prod;

  corr_scale_sat #(
    .ACC_W (ACC_W),
    .DW    (DW),
    .SHIFT (SHIFT)
  ) u_scale (
    .i_sum    (w_sum),
    .i_mode   (mode),
    .o_result (w_result)
  );

  // Lane 0 sits in the top DW bits; lanes past the current one stay zero.
  always_comb begin
    w_word = '0;
    for (int l = 0; l < LANES; l++) begin
      if (LW'(l) < r_lane_idx)
        w_word[(LANES-1-l)*DW +: DW] = r_lanes[l];
      else if (LW'(l) == r_lane_idx)
        w_word[(LANES-1-l)*DW +: DW] = w_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < TAPS; t++) r_coef[t] <= '0;
    end else if (coef_wr) begin
      r_coef[coef_idx] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_idx <= w_done ? '0 : r_idx + IW'(1);
      r_acc <= w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane_idx <= '0;
      for (int l = 0; l < LANES; l++) r_lanes[l] <= '0;
    end else if (w_done) begin
      if (w_emit) begin
        r_lane_idx <= '0;
        for (int l = 0; l < LANES; l++) r_lanes[l] <= '0;
      end else begin
        r_lanes[r_lane_idx] <= w_result;
        r_lane_idx          <= r_lane_idx + LW'(1);
      end
    end
  end

  // A new word may replace the one being consumed on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lanes <= '0;
      r_out_last  <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_lanes <= OW'(r_lane_idx) + OW'(1);
      r_out_last  <= px_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_lanes = r_out_lanes;
  assign out_last  = r_out_last;
  assign busy      = (r_idx != '0) | (r_lane_idx != '0) | r_out_valid;

endmodule

// File: tb/tb_corr_window_mac.sv
// Bench for corr_window_mac: directed scenarios with literal expectations,
// then a randomized run compared every cycle against a behavioural model.
module tb_corr_window_mac;

  localparam int DW = 8, K = 4, LANES = 4, SHIFT = 4, TAPS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        coef_wr = 1'b0;
  logic [3:0]  coef_idx = '0;
  logic [7:0]  coef_data = '0;
  logic [1:0]  mode = '0;
  logic        px_valid = 1'b0;
  logic        px_ready;
  logic [7:0]  px_data = '0;
  logic        px_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  out_lanes;
  logic        out_last;
  logic        busy;

  corr_window_mac #(.DW(DW), .K(K), .LANES(LANES), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_idx(coef_idx),
    .coef_data(coef_data), .mode(mode), .px_valid(px_valid),
    .px_ready(px_ready), .px_data(px_data), .px_last(px_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lanes(out_lanes), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a window is the sum of pixel*coef over 16 accepts.
  int          m_coef [TAPS];
  int          m_tap = 0;
  longint      m_sum = 0;
  int          m_lanes[$];
  bit          m_ov = 1'b0;
  logic [31:0] m_data = '0;
  int          m_nl = 0;
  bit          m_last = 1'b0;

  function automatic int scale(input longint s, input logic [1:0] md);
    longint r;
    if (md[0]) s = s + (1 << (SHIFT - 1));
    r = s / (1 << SHIFT);
    if (md[1] && r > 255) return 255;
    return int'(r % 256);
  endfunction

  task automatic model_step();
    bit          acc_ok;
    logic [31:0] w;
    if (!rst) begin
      foreach (m_coef[i]) m_coef[i] = 0;
      m_tap = 0; m_sum = 0; m_lanes.delete();
      m_ov = 0; m_data = '0; m_nl = 0; m_last = 0;
      return;
    end
    acc_ok = px_valid && (!m_ov || out_ready);
    if (m_ov && out_ready) m_ov = 0;
    if (acc_ok) begin
      m_sum = m_sum + longint'(px_data) * m_coef[m_tap];
      if (m_tap == TAPS - 1) begin
        m_lanes.push_back(scale(m_sum, mode));
        m_sum = 0;
        m_tap = 0;
        if (m_lanes.size() == LANES || px_last) begin
          w = '0;
          foreach (m_lanes[i]) w[(LANES-1-i)*8 +: 8] = 8'(m_lanes[i]);
          m_data = w; m_nl = m_lanes.size(); m_last = px_last; m_ov = 1;
          m_lanes.delete();
        end
      end else begin
        m_tap++;
      end
    end
    if (coef_wr) m_coef[coef_idx] = int'(coef_data);
  endtask

  initial foreach (m_coef[i]) m_coef[i] = 0;

  always @(posedge clk or negedge rst) model_step();

  always @(negedge clk) begin
    chk("px_ready", px_ready, (!m_ov || out_ready));
    chk("out_valid", out_valid, m_ov);
    chk("busy", busy, (m_tap != 0) || (m_lanes.size() != 0) || m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_data);
      chk("out_lanes", out_lanes, m_nl);
      chk("out_last", out_last, m_last);
    end
  end

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  n;
    logic        l;
  } word_t;

  word_t cap_q[$];
  bit    cap_en = 1'b1;

  always @(negedge clk)
    if (cap_en && rst && out_valid && out_ready)
      cap_q.push_back('{d: out_data, n: out_lanes, l: out_last});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit last);
    int g;
    bit ok;
    g = 0;
    px_valid = 1'b1; px_data = 8'(d); px_last = last;
    do begin
      ok = !m_ov || out_ready;
      tick();
      g++;
    end while (!ok && g < 50);
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: pixel not accepted within 50 cycles");
    end
    px_valid = 1'b0; px_last = 1'b0;
  endtask

  // First na taps carry value a, the rest 0; glitch raises px_last on tap 5.
  task automatic send_win(input int a, input int na, input bit last, input bit glitch);
    for (int i = 0; i < TAPS; i++)
      send((i < na) ? a : 0, (last && i == TAPS - 1) || (glitch && i == 5));
  endtask

  task automatic wr_coef(input int idx, input int val);
    coef_wr = 1'b1; coef_idx = 4'(idx); coef_data = 8'(val);
    tick();
    coef_wr = 1'b0;
  endtask

  task automatic check_word(input string nm, input logic [31:0] d, input int n, input bit l);
    word_t w;
    int g;
    g = 0;
    while (cap_q.size() == 0 && g < 40) begin tick(); g++; end
    if (cap_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: no word within 40 cycles", nm);
    end else begin
      w = cap_q.pop_front();
      chk({nm, "_data"}, w.d, d);
      chk({nm, "_lanes"}, w.n, n);
      chk({nm, "_last"}, w.l, l);
    end
  endtask

  initial begin
    #2;
    chk("rst_px_ready", px_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lanes", out_lanes, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    for (int i = 0; i < TAPS; i++) wr_coef(i, 1);

    mode = 2'b00;
    repeat (4) send_win(16, 16, 0, 0);
    check_word("pack", 32'h10101010, 4, 0);

    mode = 2'b00; send_win(3, 8, 0, 1);
    mode = 2'b01; send_win(3, 8, 1, 0);
    check_word("round", 32'h01020000, 2, 1);

    for (int i = 0; i < TAPS; i++) wr_coef(i, 255);
    mode = 2'b10; send_win(255, 16, 0, 0);
    mode = 2'b00; send_win(255, 16, 1, 0);
    check_word("sat", 32'hFF010000, 2, 1);

    for (int i = 0; i < TAPS; i++) wr_coef(i, 1);
    repeat (4) send_win(16, 16, 0, 0);
    out_ready = 1'b0;
    px_valid = 1'b1; px_data = 8'd5; px_last = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("bp_px_ready", px_ready, 0);
      chk("bp_out_data", out_data, 32'h10101010);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < TAPS; i++) send(5, 0);
    send_win(5, 16, 1, 0);
    check_word("bp_first", 32'h10101010, 4, 0);
    check_word("bp_resume", 32'h05050000, 2, 1);

    for (int i = 0; i < 7; i++) send(9, 0);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_px_ready", px_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_lanes", out_lanes, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    for (int i = 0; i < TAPS; i++) wr_coef(i, 1);

    coef_wr = 1'b1; coef_idx = 4'd0; coef_data = 8'd100;
    send(16, 0);
    coef_wr = 1'b0;
    for (int i = 1; i < TAPS; i++) send(16, i == TAPS - 1);
    check_word("coll_old", 32'h10000000, 1, 1);
    send_win(1, 1, 1, 0);
    check_word("coll_new", 32'h06000000, 1, 1);

    cap_en = 1'b0;
    for (int i = 0; i < TAPS; i++) wr_coef(i, $urandom_range(255));
    for (int c = 0; c < 4000; c++) begin
      px_valid  = ($urandom_range(3) != 0);
      px_data   = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(255));
      px_last   = ($urandom_range(7) == 0);
      mode      = 2'($urandom_range(3));
      out_ready = ($urandom_range(3) != 0);
      coef_wr   = ($urandom_range(15) == 0);
      coef_idx  = 4'($urandom_range(15));
      coef_data = 8'($urandom_range(255));
      if (c == 2000) rst = 1'b0;
      if (c == 2001) begin
        rst = 1'b1;
        for (int i = 0; i < TAPS; i++) wr_coef(i, $urandom_range(255));
      end
      tick();
    end
    px_valid = 1'b0; coef_wr = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/corr_window_mac.md
# corr_window_mac

Parametrised correlation back-end for the image-filter datapath. Multiplies a stream of K×K window pixels against a loadable K×K coefficient set and accumulates one dot product per window. Scales each result with a selectable truncate, round or saturate rule and packs LANES results into one memory word for the write port. Replaces the fixed 4×4, 8-bit, truncate-only MAC/write-buffer pair with a ready/valid block that handles partial last words.

## Interface
Parameters:
- DW, 8: pixel, coefficient and output-lane width (unsigned)
- K, 4: window edge; K*K taps per window
- LANES, 4: results per output word; word width is LANES*DW
- SHIFT, 4: right shift applied to the accumulator before narrowing
- ACC_W, 2*DW+$clog2(K*K): accumulator width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- coef_wr  in  1  write one coefficient
- coef_idx  in  $clog2(K*K)  tap index, row-major
- coef_data  in  DW  coefficient value
- mode  in  2  [0] round-half-up, [1] saturate; sampled when a window completes
- px_valid  in  1  pixel offered
- px_ready  out  1  pixel accepted when px_valid & px_ready
- px_data  in  DW  pixel, row-major within the window
- px_last  in  1  final window of frame; meaningful only on the window's last tap
- out_valid  out  1  packed word available
- out_ready  in  1  consumer takes the word
- out_data  out  LANES*DW  lane 0 in the most significant DW bits
- out_lanes  out  $clog2(LANES+1)  count of filled lanes (1..LANES)
- out_last  out  1  word closes the frame
- busy  out  1  tap index ≠ 0, lane index ≠ 0, or out_valid

## Operation
- **Coefficient file:** K*K×DW registers. coef_wr writes coef[coef_idx] at the clock edge. A pixel accepted in the same cycle at the same index uses the old value.
- **Tap counter (idx):**
  - Range 0..K*K-1; advances on each accepted pixel and wraps to 0 after K*K-1.
  - At each accepted pixel: acc ← (idx==0 ? 0 : acc) + px_data*coef[idx], full ACC_W precision, no overflow possible.
- **Window completion** (accepted pixel with idx==K*K-1):
  - Form sum s = acc + product.
  - Round: if mode[0], s ← s + 2^(SHIFT-1); the adder is ACC_W+1 bits wide. When SHIFT=0 the rounding term is 0.
  - Shift: r = s >> SHIFT.
  - Saturate: if mode[1] and r > 2^DW-1, the result is 2^DW-1; otherwise the result is r[DW-1:0] (wrap).
  - The result is written to lane[lane_idx].
- **Word emission:**
  - Trigger: the completing window fills the last lane (lane_idx==LANES-1), or px_last is high on its final tap.
  - Action: out_data ← lanes, with unfilled lanes forced to 0. out_lanes ← lane_idx+1. out_last ← px_last. lane_idx ← 0 and the lane registers clear.
  - Otherwise lane_idx increments.
- **Backpressure:**
  - px_ready = ~out_valid | out_ready.
  - While out_valid & ~out_ready: no pixel is accepted, and the accumulator, idx, lanes and output hold.
- **px_last:** ignored when idx ≠ K*K-1.
- **Reset mid-window:** the partial window and partial lanes are discarded; there is no flush.

## Timing
- **Reset values:** px_ready=1, out_valid=0, out_data=0, out_lanes=0, out_last=0, busy=0. Accumulator, idx, lane_idx, lane registers and the coefficient file are all 0.
- **Latency:** out_valid rises on the edge that accepts the emitting tap, so it is visible in the next cycle.
- **Throughput:** one pixel per cycle. Full throughput holds with out_ready tied high.
- **Output handshake:**
  - out_valid & out_ready in cycle n: the word is consumed at the end of n, and out_valid falls unless a new word is emitted on the same edge.
  - Same-edge replacement is legal: the new word loads and out_valid stays 1.
- **Output stability:** out_data, out_lanes and out_last stay stable while out_valid & ~out_ready.
- **mode** is sampled only on completing taps; changing it mid-window affects only that window's scaling.

## Structure
- **Shared package corr_pkg:**
  - Mode bit positions: MODE_RND=0, MODE_SAT=1.
  - Default parameter constants.
  - Function for accumulator width.
- **Sub-module corr_scale_sat:**
  - Purely combinational.
  - Input: ACC_W sum plus mode. Output: DW lane value.
  - Parameters: ACC_W, DW, SHIFT.
  - Instantiated once.
- **Top-level contents:** the coefficient file, the idx and lane counters, the accumulator and the output register.

## Test plan
All scenarios use the defaults (DW=8, K=4, LANES=4, SHIFT=4).
1. **Basic packing:** all coefficients 1; four windows of sixteen pixels each 16, mode=00, out_ready=1 -> one word 0x10101010, out_lanes=4, out_last=0, one cycle after the 64th accept.
2. **Rounding:** coefficients 1; window pixels sum to 24 -> mode=00 gives lane 0x01, mode=01 gives 0x02.
3. **Saturation:** all coefficients and pixels 255 (sum 1040400) -> mode=10 gives 0xFF, mode=00 gives 0x01 (65025 mod 256).
4. **Partial last word:** two windows with px_last on the 32nd tap -> out_lanes=2, out_last=1, low 16 bits of out_data = 0.
5. **Backpressure:** hold out_ready=0 after the first word -> px_ready=0, and out_data stays stable for 10 cycles; release -> stream resumes without losing or duplicating pixels.
6. **Reset and coefficient collision:**
   - Assert rst after 7 taps -> all outputs return to their reset values immediately, and the next window starts at idx 0.
   - Write coef[0] in the same cycle as the tap-0 accept -> the old coefficient is used for that tap.
